// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

interface if_fetch_unit_if #(
  parameter int W = `CPU_WIDTH
);
  logic         imem_req_o;
  logic [W-1:0] imem_addr_o;
  logic         imem_gnt_i;
  logic         imem_rvalid_i;
  logic [W-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited memory requests, response FIFO, redirect flush.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (halt on misaligned redirect target).
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef RESET_PC_VALUE
`define RESET_PC_VALUE 32'h8000_0000
`endif

module if_fetch_unit #(
  parameter logic [`CPU_WIDTH-1:0] RESET_PC   = `RESET_PC_VALUE,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [`CPU_WIDTH-1:0] redirect_pc_i,
  input  logic                  id_stall_i,
  if_fetch_unit_if.master       imem,
  output logic [`CPU_WIDTH-1:0] fetch_pc_o,
  output logic                  if_valid_o,
  output logic [`CPU_WIDTH-1:0] if_pc_o,
  output logic [`CPU_WIDTH-1:0] if_inst_o,
  output logic                  fetch_misalign_o
);

  localparam int W     = `CPU_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [W-1:0]     fpc;
  logic [W-1:0]     rpc;
  logic [CNT_W-1:0] outst;
  logic [CNT_W-1:0] outst_next;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [W-1:0]     pc_mem   [FIFO_DEPTH];
  logic [W-1:0]     inst_mem [FIFO_DEPTH];
  logic [W-1:0]     target;
  logic             halted;
  logic             grant;
  logic             resp;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   credit_used;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign;
  logic redir_bad;

  assign target           = redirect_pc_i;
  assign redir_bad        = redirect_pc_i[1:0] != 2'b00;
  assign fetch_misalign_o = misalign;

  // Misalign flag and halt are sticky until the next redirect re-evaluates them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
      halted   <= 1'b0;
    end else if (redirect_i) begin
      misalign <= redir_bad;
      halted   <= redir_bad;
    end
  end
`else
  logic unused_pc_lsb;

  assign target           = {redirect_pc_i[W-1:2], 2'b00};
  assign unused_pc_lsb    = ^redirect_pc_i[1:0];
  assign halted           = 1'b0;
  assign fetch_misalign_o = 1'b0;
`endif

  // Outstanding requests plus buffered words never exceed the buffer size
  assign credit_used   = {1'b0, outst} + {1'b0, fifo_count};
  assign imem.imem_req_o  = !redirect_i && !halted && (credit_used < {1'b0, DEPTH_C});
  assign imem.imem_addr_o = fpc;
  assign fetch_pc_o       = fpc;

  assign grant = imem.imem_req_o && imem.imem_gnt_i;
  // Responses with nothing outstanding predate a reset and are ignored
  assign resp  = imem.imem_rvalid_i && (outst != {CNT_W{1'b0}});
  assign push  = resp && (drop == {CNT_W{1'b0}}) && !redirect_i && !halted;
  assign pop   = if_valid_o && !id_stall_i;

  assign if_valid_o = (fifo_count != {CNT_W{1'b0}}) && !redirect_i;
  assign if_pc_o    = pc_mem[rd_ptr];
  assign if_inst_o  = inst_mem[rd_ptr];

  // Next outstanding count after this cycle's grant and response
  always_comb begin
    outst_next = outst;
    if (grant && !resp) begin
      outst_next = outst + CNT_W'(1);
    end else if (resp && !grant) begin
      outst_next = outst - CNT_W'(1);
    end else begin
      outst_next = outst;
    end
  end

  // Fetch PC, response tracking and instruction buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc        <= RESET_PC;
      rpc        <= RESET_PC;
      outst      <= {CNT_W{1'b0}};
      drop       <= {CNT_W{1'b0}};
      fifo_count <= {CNT_W{1'b0}};
      rd_ptr     <= {PTR_W{1'b0}};
      wr_ptr     <= {PTR_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]   <= {W{1'b0}};
        inst_mem[i] <= {W{1'b0}};
      end
    end else begin
      outst <= outst_next;
      if (redirect_i) begin
        // In-flight words, including one arriving now, belong to the wrong path
        fpc        <= target;
        rpc        <= target;
        drop       <= outst_next;
        fifo_count <= {CNT_W{1'b0}};
        rd_ptr     <= {PTR_W{1'b0}};
        wr_ptr     <= {PTR_W{1'b0}};
      end else begin
        if (grant) begin
          fpc <= fpc + W'(4);
        end
        if (resp && (drop != {CNT_W{1'b0}})) begin
          drop <= drop - CNT_W'(1);
        end
        if (push) begin
          pc_mem[wr_ptr]   <= rpc;
          inst_mem[wr_ptr] <= imem.imem_rdata_i;
          wr_ptr           <= wr_ptr + PTR_W'(1);
          rpc              <= rpc + W'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CNT_W'(1);
          2'b01:   fifo_count <= fifo_count - CNT_W'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a memory model serves granted requests, a monitor checks delivered {pc, inst}.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic [31:0] fetch_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        fetch_misalign;

  int checks = 0;
  int passes = 0;
  int ovf    = 0;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  int          pend_n    = 0;
  logic [31:0] pend_head = 32'h0;
  int          gnt_total = 0;
  int          gnt_count = 0;
  bit          mem_auto  = 1'b1;
  bit          man_rvalid = 1'b0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  if_fetch_unit_if #(.W(32)) bus();

  if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .id_stall_i       (id_stall),
    .imem             (bus),
    .fetch_pc_o       (fetch_pc),
    .if_valid_o       (if_valid),
    .if_pc_o          (if_pc),
    .if_inst_o        (if_inst),
    .fetch_misalign_o (fetch_misalign)
  );

  always #5 clk = ~clk;

  assign bus.imem_gnt_i    = (gnt_count < gnt_total);
  assign bus.imem_rvalid_i = (pend_n > 0) && (mem_auto || man_rvalid);
  assign bus.imem_rdata_i  = data_of(pend_head);

  // Memory model: in-order responses, one cycle after grant at the earliest; ignores reset
  always @(posedge clk) begin
    if (bus.imem_rvalid_i) void'(pend_q.pop_front());
    if (bus.imem_req_o && bus.imem_gnt_i) begin
      pend_q.push_back(bus.imem_addr_o);
      gnt_count <= gnt_count + 1;
    end
    pend_n    <= pend_q.size();
    pend_head <= (pend_q.size() > 0) ? pend_q[0] : 32'h0;
  end

  // Monitor: every instruction taken by ID must be the next expected one
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && if_valid && !id_stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL deliver: got pc=%h inst=%h, required no delivery", if_pc, if_inst);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst)
          $display("FAIL deliver: got pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, e.pc, e.inst);
        else
          passes++;
      end
    end
  end

  // A push into a full buffer must never happen
  always @(negedge clk) begin
    if (!rst && dut.push && dut.fifo_count == 2'd2) ovf <= ovf + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
    else passes++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      exp_q.push_back({a, data_of(a)});
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    redirect = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
    chk("rst_fetch_pc", fetch_pc, RST_PC);

    // Reset release: sequential stream from RESET_PC
    cyc(); rst = 1'b0; gnt_total += 6; expect_run(RST_PC, 6);
    @(negedge clk);
    chk("req_after_release", {31'd0, bus.imem_req_o}, 32'd1);
    chk("addr_after_release", bus.imem_addr_o, RST_PC);
    lat = 0;
    while (!if_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", 32'(lat), 32'd2);
    chk("first_if_pc", if_pc, RST_PC);
    wait_drain("stream_drain");

    // ID stall: buffer fills, requests stop, nothing lost after release
    cyc(); id_stall = 1'b1; gnt_total += 4; expect_run(32'h8000_0018, 4);
    repeat (4) cyc();
    @(negedge clk);
    chk("stall_req_low", {31'd0, bus.imem_req_o}, 32'd0);
    chk("stall_head_valid", {31'd0, if_valid}, 32'd1);
    chk("stall_head_pc", if_pc, 32'h8000_0018);
    cyc(); id_stall = 1'b0;
    wait_drain("stall_drain");

    // Redirect with two requests outstanding, answered 1 and 3 cycles later
    mem_auto = 1'b0;
    cyc(); gnt_total += 2;
    cyc();
    cyc();
    chk("pre_redirect_fpc", fetch_pc, 32'h8000_0030);
    redirect = 1'b1; redirect_pc = 32'h8000_0100; gnt_total += 3; expect_run(32'h8000_0100, 3);
    cyc(); redirect = 1'b0; man_rvalid = 1'b1;
    cyc(); man_rvalid = 1'b0;
    cyc(); man_rvalid = 1'b1;
    cyc(); man_rvalid = 1'b0; mem_auto = 1'b1;
    wait_drain("redirect_drain");

    // Redirect in the same cycle as a response and a would-be pop
    cyc(); gnt_total += 3;
    cyc();
    cyc();
    chk("coinc_pre_valid", {31'd0, if_valid}, 32'd1);
    chk("coinc_pre_rvalid", {31'd0, bus.imem_rvalid_i}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h8000_0300; gnt_total += 1; expect_run(32'h8000_0300, 2);
    @(negedge clk);
    chk("coinc_valid_low", {31'd0, if_valid}, 32'd0);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("coinc_fifo_empty", {31'd0, if_valid}, 32'd0);
    chk("coinc_target_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("coinc_target_addr", bus.imem_addr_o, 32'h8000_0300);
    wait_drain("coinc_drain");

`ifdef IFETCH_MISALIGN_CHECK_EN
    cyc(); redirect = 1'b1; redirect_pc = 32'h8000_0102;
    cyc(); redirect = 1'b0; gnt_total += 2;
    repeat (3) begin
      @(negedge clk);
      chk("misalign_flag", {31'd0, fetch_misalign}, 32'd1);
      chk("misalign_no_req", {31'd0, bus.imem_req_o}, 32'd0);
    end
    cyc(); redirect = 1'b1; redirect_pc = 32'h8000_0200; expect_run(32'h8000_0200, 2);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("misalign_cleared", {31'd0, fetch_misalign}, 32'd0);
    chk("resume_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("resume_addr", bus.imem_addr_o, 32'h8000_0200);
`else
    cyc(); redirect = 1'b1; redirect_pc = 32'h8000_0102; gnt_total += 2; expect_run(32'h8000_0100, 2);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("align_force_flag", {31'd0, fetch_misalign}, 32'd0);
    chk("align_force_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("align_force_addr", bus.imem_addr_o, 32'h8000_0100);
`endif
    wait_drain("misalign_drain");

    // Reset with two requests outstanding; stale responses straddle the release
    mem_auto = 1'b0;
    cyc(); gnt_total += 2;
    cyc();
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_fetch_pc", fetch_pc, RST_PC);
    cyc(); man_rvalid = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("midrst_stale_rvalid", {31'd0, bus.imem_rvalid_i}, 32'd1);
    chk("midrst_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("midrst_addr", bus.imem_addr_o, RST_PC);
    cyc(); man_rvalid = 1'b0; mem_auto = 1'b1; gnt_total += 3; expect_run(RST_PC, 3);
    wait_drain("midrst_drain");

    chk("no_fifo_overflow", 32'(ovf), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
